// File: rtl/cos_pkg.sv
// Shared constants and state encoding for Q16.16 trig helpers.
// Feature macro used by this slice: COS_RR_FAST_EN.
package cos_pkg;

    localparam int Q_W = 32;

    localparam logic [Q_W-1:0] TWO_PI_Q16  = 32'd411775;
    localparam logic [Q_W-1:0] PI_Q16      = 32'd205887;
    localparam logic [Q_W-1:0] HALF_PI_Q16 = 32'd102944;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_FOLD   = 2'd2,
        ST_DONE   = 2'd3
    } rr_state_t;

endpackage

// File: rtl/cos_quadrant_fold.sv
// Folds an angle in [0, 2pi) to [0, pi/2] plus a cosine negate flag.
// Purely combinational.
module cos_quadrant_fold
    import cos_pkg::*;
(
    input  logic [Q_W-1:0] rem,
    output logic [Q_W-1:0] angle,
    output logic           neg
);

    logic [Q_W-1:0] r;

    always_comb begin
        r     = rem;
        angle = '0;
        neg   = 1'b0;
        if (r > PI_Q16) r = TWO_PI_Q16 - r;
        if (r > HALF_PI_Q16) begin
            angle = PI_Q16 - r;
            neg   = 1'b1;
        end else begin
            angle = r;
        end
    end

endmodule

// File: rtl/cos_range_reduce.sv
// Reduces a signed Q16.16 angle to [0, pi/2] with a cosine negate flag.
// Optional COS_RR_FAST_EN: operands already below 2pi skip REDUCE.
module cos_range_reduce
    import cos_pkg::*;
#(
    parameter int RED_STEPS = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [Q_W-1:0] x_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_W-1:0]        angle_out,
    output logic                  neg
);

    localparam int SW = (RED_STEPS > 1) ? $clog2(RED_STEPS) : 1;
    localparam int CW = Q_W + RED_STEPS;

    rr_state_t      state, state_n;
    logic [Q_W-1:0] rem, rem_n;
    logic [SW-1:0]  step, step_n;
    logic [Q_W-1:0] angle_n;
    logic           neg_n;

    logic [Q_W-1:0] x_abs;
    logic [CW-1:0]  cmp;
    logic [Q_W-1:0] f_angle;
    logic           f_neg;

    // Two's-complement magnitude; 0x8000_0000 maps to 2^31 unsigned.
    assign x_abs = x_in[Q_W-1] ? (~$unsigned(x_in) + 32'd1)
                               : $unsigned(x_in);

    assign cmp = {{RED_STEPS{1'b0}}, TWO_PI_Q16} << step;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    cos_quadrant_fold u_fold (
        .rem   (rem),
        .angle (f_angle),
        .neg   (f_neg)
    );

    always_comb begin
        state_n = state;
        rem_n   = rem;
        step_n  = step;
        angle_n = angle_out;
        neg_n   = neg;
        unique case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_n  = x_abs;
                    step_n = SW'(RED_STEPS - 1);
`ifdef COS_RR_FAST_EN
                    if (x_abs < TWO_PI_Q16) state_n = ST_FOLD;
                    else                    state_n = ST_REDUCE;
`else
                    state_n = ST_REDUCE;
`endif
                end
            end
            ST_REDUCE: begin
                if ({{RED_STEPS{1'b0}}, rem} >= cmp)
                    rem_n = rem - cmp[Q_W-1:0];
                if (step == '0) state_n = ST_FOLD;
                else            step_n  = step - 1'b1;
            end
            ST_FOLD: begin
                angle_n = f_angle;
                neg_n   = f_neg;
                state_n = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rem       <= '0;
            step      <= '0;
            angle_out <= '0;
            neg       <= 1'b0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            step      <= step_n;
            angle_out <= angle_n;
            neg       <= neg_n;
        end
    end

endmodule

// File: tb/tb_cos_range_reduce.sv
// Scoreboard bench for cos_range_reduce (honours COS_RR_FAST_EN).
module tb_cos_range_reduce;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] x_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        angle_out;
    logic               neg;

    cos_range_reduce dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle_out (angle_out),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] angle;
        logic        neg;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: direct modulo and quadrant fold on 64-bit integers.
    function automatic exp_t model(input logic signed [31:0] x);
        exp_t    e;
        longint  a;
        longint  m;
        a = longint'(x);
        if (a < 0) a = -a;
        m = a % 64'd411775;
        if (m > 205887) m = 411775 - m;
        if (m > 102944) begin
            e.angle = 32'(205887 - m);
            e.neg   = 1'b1;
        end else begin
            e.angle = 32'(m);
            e.neg   = 1'b0;
        end
        e.lat = 16;
`ifdef COS_RR_FAST_EN
        if (a < 411775) e.lat = 2;
`endif
        return e;
    endfunction

    task automatic issue(input logic signed [31:0] x);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x_in     = x;
        sb.push_back(model(x));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        logic [31:0] a0;
        logic        n0;
        lat  = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_angle"}, angle_out, e.angle);
        chk({tag, "_neg"}, 32'(neg), 32'(e.neg));
        a0 = angle_out;
        n0 = neg;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x_in     = $signed($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_angle"}, angle_out, a0);
            chk({tag, "_hold_neg"}, 32'(neg), 32'(n0));
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_xfer_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic signed [31:0] x, input string tag);
        issue(x);
        collect(0, tag);
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_angle", angle_out, 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'sd0, "zero");
        run(32'sd205887, "pi");
        run(-32'sd65536, "neg_one");
        run(32'sd262144, "four");
        run(32'sd458752, "seven");
        run(32'sh8000_0000, "min_int");
        run(32'sd102944, "half_pi");
        run(32'sd411775, "two_pi");
        run(32'sh7fff_ffff, "max_int");
        run(-32'sd205888, "neg_pi_p");

        issue(32'sd262144);
        collect(5, "bp");

        // Abort an operand mid-REDUCE; it must leave no result behind.
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 32'sd458752;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) chk("abort_ghost", 32'(out_valid), 32'd0);
        end
        run(32'sd65536, "post_rst");

        for (int i = 0; i < 8; i++)
            run($signed($urandom), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
